uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised RS232 transmitter with an integrated bit-rate counter, configurable data width, per-frame parity mode and one or two stop bits.
- Accepts a byte/word through a valid/ready handshake and serialises it LSB-first on tx_line.
- Reports busy and a one-cycle done pulse.
- Sits between the processor's memory-mapped UART register block and the board pin.
- Replaces the fixed 8N1 transmitter FSM and its external bit-rate and bit-count helpers.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 434, clk cycles per serial bit (e.g. 50 MHz / 115200); must be >= 2.
CNT_W, $clog2(CLKS_PER_BIT), bit-rate counter width; derived, not overridden.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tx_data  in  DATA_W  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a word
parity_mode  in  2  00 none, 01 odd, 10 even, 11 treated as none; sampled at accept
stop2  in  1  1 = two stop bits, 0 = one; sampled at accept
tx_line  out  1  serial output, idle high, registered
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: tx_line=1, busy=0, done=0, state=IDLE, all counters 0. tx_ready=0 while rst is high.
- Reset mid-frame: tx_line returns high immediately and the frame is abandoned. No done pulse.
- tx_ready = (state==IDLE) && !rst. Combinational from state only, with no dependence on tx_valid.
- Accept happens on the clk edge where tx_valid && tx_ready.
  - At that edge, capture tx_data, parity_mode and stop2 into shadow registers. Input changes after accept have no effect.
  - Parity bit is computed at accept: even = XOR of the DATA_W bits; odd = inverted XOR.
- States: IDLE, START, DATA, PARITY, STOP. Encodings are Gray where adjacent.
  - IDLE -> START on accept. tx_line goes 0 from the cycle after the accept edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: bit index i from 0 to DATA_W-1, each bit held CLKS_PER_BIT cycles, LSB first.
  - DATA -> PARITY after bit DATA_W-1 if parity is enabled, else DATA -> STOP.
  - PARITY: parity bit held CLKS_PER_BIT cycles, then -> STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT if stop2. Then -> IDLE.
- Bit-rate counter: cleared on every bit transition and on accept. A tick is generated when count == CLKS_PER_BIT-1. No drift is allowed; every bit is exactly CLKS_PER_BIT cycles.
- Bit counter is 4 bits and counts data bits plus extra stop bits. It is cleared on entry to DATA and to STOP.
- busy = 1 from the cycle after accept through the last STOP cycle. It is 0 in IDLE.
- done = 1 for exactly one cycle: the first IDLE cycle after STOP. tx_ready is also 1 in that cycle.
- Back-to-back frames: if tx_valid is held, the next accept occurs in that first IDLE cycle. Inter-frame idle-high gap is exactly 1 clk beyond the stop bit(s).
- Frame duration from accept edge to done: (1 + DATA_W + P + S) * CLKS_PER_BIT + 1 cycles, where P is 0 or 1 and S is 1 or 2.
- All outputs are registered except tx_ready.

Decomposition:
- Shared package uart_pkg:
  - Parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - State encodings for tx.
  - Default CLKS_PER_BIT localparam, also reused by the future parametrised RX.
- Sub-module uart_baud_tick: CLKS_PER_BIT counter with a synchronous clear and a tick output, parametrised by CLKS_PER_BIT. It is shared with the RX block.
- FSM, shift register, parity and bit counter stay in uart_tx_param.

Test Plan:
- CLKS_PER_BIT=4, DATA_W=8, 8N1, send 0xA5 -> tx_line = 0,1,0,1,0,0,1,0,1,1. Each level lasts exactly 4 cycles. done pulses at cycle 41 after accept. busy high for 40 cycles.
- Even parity, send 0x07 -> parity bit 1. Odd parity, send 0x07 -> parity bit 0. parity_mode=11 -> no parity bit.
- stop2=1, send 0xFF -> stop level lasts 8 cycles. Change parity_mode and stop2 mid-frame -> the frame is unchanged.
- tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly 1 idle-high cycle. One done pulse per frame. tx_ready high only in IDLE cycles.
- Assert rst during DATA bit 3 -> tx_line=1 immediately, busy=0, no done. After release, a new 0x3C frame transmits correctly.
- DATA_W=5 and DATA_W=9 builds, send all-ones and 0x155 -> correct bit count and parity. Frame length matches the formula.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transmitter and the receiver
// that will reuse the same bit-rate counter.
//
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity_mode encodings (2'b11 = none)
//   CLKS_PER_BIT_DEFAULT          : 50 MHz / 115200 baud
//   tx_state_e                    : transmitter state encoding
//   parity_enabled()              : true when a parity bit is sent
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    // Neighbouring states along the normal frame path differ in one bit.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'b000,
        TX_START  = 3'b001,
        TX_DATA   = 3'b011,
        TX_PARITY = 3'b010,
        TX_STOP   = 3'b110
    } tx_state_e;

    // Mode 2'b11 is reserved and behaves like no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// ---------------------------------------------------------------------------
// uart_tx_param_if
// Word handshake between the UART register block (master) and the
// transmitter (slave).
//
// Signals:
//   tx_data     word to send, DATA_W bits, LSB goes out first
//   tx_valid    tx_data / parity_mode / stop2 are valid
//   tx_ready    transmitter can accept a word this cycle
//   parity_mode 00 none, 01 odd, 10 even, 11 none
//   stop2       1 = two stop bits, 0 = one
// ---------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    import uart_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        parity_mode;
    logic              stop2;

    modport master (
        output tx_data,
        output tx_valid,
        output parity_mode,
        output stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  parity_mode,
        input  stop2,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-rate counter shared by the UART transmitter and receiver. Counts
// 0 .. CLKS_PER_BIT-1 and raises tick while the count sits at the terminal
// value; the count wraps to 0 on the tick so consecutive bits are exactly
// CLKS_PER_BIT cycles long with no drift.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   clr   in   synchronous clear, holds the count at 0
//   tick  out  high in the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised RS232 transmitter. Takes one word per valid/ready handshake
// and sends start bit, DATA_W data bits LSB first, an optional parity bit
// and one or two stop bits on tx_line. Data, parity mode and stop count are
// captured at accept, so the host may change its inputs during a frame.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset; abandons any frame
//   bus      slave side of uart_tx_param_if (tx_data, tx_valid, tx_ready,
//            parity_mode, stop2); tx_ready is the only combinational output
//   tx_line  out  serial line, idle high, registered
//   busy     out  high from the cycle after accept to the last stop cycle
//   done     out  one-cycle pulse in the first idle cycle after a frame
//
// State table:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   TX_IDLE   | line high, tx_ready high, waiting for tx_valid
//   TX_START  | start bit (low) for one bit period
//   TX_DATA   | data bit bit_cnt from the shift register, LSB first
//   TX_PARITY | captured parity bit, only when parity is enabled
//   TX_STOP   | stop bit(s) high; bit_cnt tracks the second stop bit
// ---------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus,
    output logic            tx_line,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    tx_state_e         state;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_en;
    logic              stop2_q;
    logic [3:0]        bit_cnt;

    logic accept;
    logic bit_tick;
    logic baud_clr;

    assign bus.tx_ready = (state == TX_IDLE) && !rst;
    assign accept       = bus.tx_valid && bus.tx_ready;

    // Holding the counter clear while idle means the first start-bit cycle
    // always begins from 0, which also covers the clear on accept.
    assign baud_clr = (state == TX_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            par_en  <= 1'b0;
            stop2_q <= 1'b0;
            bit_cnt <= '0;
            tx_line <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (accept) begin
                        shreg   <= bus.tx_data;
                        par_en  <= parity_enabled(bus.parity_mode);
                        // Even parity is the XOR of the data; odd inverts it.
                        par_bit <= (^bus.tx_data) ^ (bus.parity_mode == PAR_ODD);
                        stop2_q <= bus.stop2;
                        state   <= TX_START;
                        tx_line <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                TX_START: begin
                    if (bit_tick) begin
                        state   <= TX_DATA;
                        bit_cnt <= '0;
                        tx_line <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end

                TX_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en) begin
                                state   <= TX_PARITY;
                                tx_line <= par_bit;
                            end else begin
                                state   <= TX_STOP;
                                tx_line <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx_line <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end

                TX_PARITY: begin
                    if (bit_tick) begin
                        state   <= TX_STOP;
                        bit_cnt <= '0;
                        tx_line <= 1'b1;
                    end
                end

                TX_STOP: begin
                    if (bit_tick) begin
                        if (stop2_q && (bit_cnt == 4'd0)) begin
                            bit_cnt <= 4'd1;
                        end else begin
                            state   <= TX_IDLE;
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= TX_IDLE;
                    bit_cnt <= '0;
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [8:0] drv_data  = '0;
    logic       drv_valid = 1'b0;
    logic [1:0] drv_pm    = 2'b00;
    logic       drv_s2    = 1'b0;

    logic line_a, busy_a, done_a;
    logic line_b, busy_b, done_b;
    logic line_c, busy_c, done_c;
    logic obs_line, obs_busy, obs_done, obs_ready;

    int n_cmp = 0;
    int n_fail = 0;
    int cur_cyc = 0;
    int last_busy_n = 0;
    int last_done_at = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_W(8)) if_a ();
    uart_tx_param_if #(.DATA_W(5)) if_b ();
    uart_tx_param_if #(.DATA_W(9)) if_c ();

    assign if_a.tx_data     = drv_data[7:0];
    assign if_a.tx_valid    = drv_valid && (sel == 2'd0);
    assign if_a.parity_mode = drv_pm;
    assign if_a.stop2       = drv_s2;
    assign if_b.tx_data     = drv_data[4:0];
    assign if_b.tx_valid    = drv_valid && (sel == 2'd1);
    assign if_b.parity_mode = drv_pm;
    assign if_b.stop2       = drv_s2;
    assign if_c.tx_data     = drv_data;
    assign if_c.tx_valid    = drv_valid && (sel == 2'd2);
    assign if_c.parity_mode = drv_pm;
    assign if_c.stop2       = drv_s2;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave),
        .tx_line(line_a), .busy(busy_a), .done(done_a));
    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave),
        .tx_line(line_b), .busy(busy_b), .done(done_b));
    uart_tx_param #(.DATA_W(9), .CLKS_PER_BIT(2)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave),
        .tx_line(line_c), .busy(busy_c), .done(done_c));

    always_comb begin
        obs_line  = line_a;
        obs_busy  = busy_a;
        obs_done  = done_a;
        obs_ready = if_a.tx_ready;
        case (sel)
            2'd1: begin
                obs_line = line_b; obs_busy = busy_b;
                obs_done = done_b; obs_ready = if_b.tx_ready;
            end
            2'd2: begin
                obs_line = line_c; obs_busy = busy_c;
                obs_done = done_c; obs_ready = if_c.tx_ready;
            end
            default: ;
        endcase
    end

    function automatic int cur_dw();
        case (sel)
            2'd1:    return 5;
            2'd2:    return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int cur_cpb();
        case (sel)
            2'd1:    return 3;
            2'd2:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d sel=%0d observed=%0h expected=%0h",
                   tag, cur_cyc, sel, obs, exp);
        end
    endtask

    // Line level per bit period: start, data LSB first, optional parity
    // chosen so the total count of ones is even/odd, then stop bit(s).
    task automatic build_frame(input logic [8:0] data, input logic [1:0] pm, input logic s2);
        int dw;
        int ones;
        dw = cur_dw();
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pm == PAR_EVEN)     exp_q.push_back((ones % 2) == 1);
        else if (pm == PAR_ODD) exp_q.push_back((ones % 2) == 0);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [8:0] data, input logic [1:0] pm, input logic s2);
        @(negedge clk);
        cur_cyc = 0;
        check("ready_before_accept", obs_ready, 1);
        check("done_cleared", obs_done, 0);
        drv_data  = data;
        drv_pm    = pm;
        drv_s2    = s2;
        drv_valid = 1'b1;
        @(posedge clk);
    endtask

    // Checks every cycle from the one after the accept edge to the done
    // cycle. With keep set, tx_valid stays high and the next word is
    // presented so the following accept lands in the done cycle.
    task automatic monitor_frame(input logic [8:0] data, input logic [1:0] pm, input logic s2,
                                 input bit keep, input logic [8:0] nd, input logic [1:0] npm,
                                 input logic ns2, input int stop_at);
        int len;
        int cpb;
        int busy_n;
        int done_at;
        bit exp_line;
        build_frame(data, pm, s2);
        cpb = cur_cpb();
        len = exp_q.size() * cpb;
        busy_n = 0;
        done_at = 0;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            cur_cyc = c;
            exp_line = (c <= len) ? exp_q[(c - 1) / cpb] : 1'b1;
            check("tx_line", obs_line, exp_line);
            check("busy", obs_busy, c <= len);
            check("done", obs_done, c == len + 1);
            check("tx_ready", obs_ready, c == len + 1);
            if (obs_busy === 1'b1) busy_n++;
            if (obs_done === 1'b1) done_at = c;
            if (c == stop_at) return;
            if (keep && c == 1) begin
                drv_data = nd;
                drv_pm   = npm;
                drv_s2   = ns2;
            end else if (!keep && (c == 1 || c == len / 2)) begin
                drv_valid = (c == 1) ? 1'b0 : drv_valid;
                drv_data  = 9'($urandom);
                drv_pm    = 2'($urandom);
                drv_s2    = 1'($urandom);
            end
        end
        cur_cyc = len + 1;
        check("busy_cycles", busy_n, len);
        check("done_cycle", done_at, len + 1);
        last_busy_n = busy_n;
        last_done_at = done_at;
    endtask

    task automatic send(input logic [8:0] data, input logic [1:0] pm, input logic s2);
        start_frame(data, pm, s2);
        monitor_frame(data, pm, s2, 1'b0, 9'h0, 2'b00, 1'b0, 0);
    endtask

    initial begin
        logic [8:0] rd;
        logic [1:0] rp;
        logic       rs;

        #1 rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("rst_line", obs_line, 1);
            check("rst_busy", obs_busy, 0);
            check("rst_done", obs_done, 0);
            check("rst_ready", obs_ready, 0);
        end
        sel = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", obs_ready, 1);

        // 8N1 0xA5: 40 busy cycles, done 41 cycles after accept
        send(9'h0A5, PAR_NONE, 1'b0);
        check("a5_busy_40", last_busy_n, 40);
        check("a5_done_41", last_done_at, 41);

        send(9'h007, PAR_EVEN, 1'b0);
        send(9'h007, PAR_ODD, 1'b0);
        send(9'h007, 2'b11, 1'b0);
        send(9'h0FF, PAR_NONE, 1'b1);
        check("ff_stop2_busy", last_busy_n, 44);
        send(9'h03C, PAR_ODD, 1'b1);

        // back-to-back with tx_valid held
        start_frame(9'h055, PAR_NONE, 1'b0);
        monitor_frame(9'h055, PAR_NONE, 1'b0, 1'b1, 9'h0AA, PAR_NONE, 1'b0, 0);
        monitor_frame(9'h0AA, PAR_NONE, 1'b0, 1'b0, 9'h0, 2'b00, 1'b0, 0);

        // reset in the middle of data bit 3
        start_frame(9'h0C3, PAR_EVEN, 1'b0);
        monitor_frame(9'h0C3, PAR_EVEN, 1'b0, 1'b0, 9'h0, 2'b00, 1'b0, 4 * 4 + 2);
        rst = 1'b1;
        #1;
        check("midrst_line", obs_line, 1);
        check("midrst_busy", obs_busy, 0);
        check("midrst_ready", obs_ready, 0);
        drv_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_no_done", obs_done, 0);
            check("midrst_line_hold", obs_line, 1);
        end
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ready", obs_ready, 1);
        check("postrst_no_done", obs_done, 0);
        send(9'h03C, PAR_NONE, 1'b0);

        // narrow and wide builds
        sel = 2'd1;
        send(9'h01F, PAR_EVEN, 1'b0);
        send(9'h155, PAR_ODD, 1'b0);
        send(9'h01F, PAR_ODD, 1'b1);
        sel = 2'd2;
        send(9'h1FF, PAR_EVEN, 1'b0);
        send(9'h155, PAR_ODD, 1'b1);
        send(9'h155, PAR_NONE, 1'b0);

        // random frames on each build
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int k = 0; k < 6; k++) begin
                rd = 9'($urandom);
                rp = 2'($urandom_range(0, 3));
                rs = 1'($urandom_range(0, 1));
                send(rd, rp, rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
